// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT constants, bank-state enum and bit-reversal helper
// for the 512-point bit-reversed-to-natural reorder buffer.
package fft_bitrev_reorder_pkg;

  localparam int FFT_W          = 24;
  localparam int FFT_LANES      = 16;
  localparam int FFT_BEATS      = 32;
  localparam int FFT_N          = FFT_LANES * FFT_BEATS;
  localparam int FFT_LOG_LANES  = 4;
  localparam int FFT_LOG_BEATS  = 5;
  localparam int FFT_LOG_N      = FFT_LOG_LANES + FFT_LOG_BEATS;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILL,
    BANK_FULL,
    BANK_DRAIN
  } bank_state_e;

  // Reverse the low nbits of v; bits above nbits return zero.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          nbits
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[5'(i)] = v[5'(nbits - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_if.sv
// Beat-level bus of the reorder buffer: input beats in,
// natural-order beats out with valid/ready, sticky overflow.
interface fft_bitrev_reorder_if
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int W     = FFT_W,
  parameter int LANES = FFT_LANES
);

  logic                din_en;
  logic signed [W-1:0] din_re [LANES];
  logic signed [W-1:0] din_im [LANES];
  logic                dout_valid;
  logic                dout_ready;
  logic signed [W-1:0] dout_re [LANES];
  logic signed [W-1:0] dout_im [LANES];
  logic                dout_last;
  logic                ovf;

  modport master (
    output din_en, din_re, din_im, dout_ready,
    input  dout_valid, dout_re, dout_im, dout_last, ovf
  );

  modport slave (
    input  din_en, din_re, din_im, dout_ready,
    output dout_valid, dout_re, dout_im, dout_last, ovf
  );

endinterface

// File: rtl/fft_reorder_bank.sv
// One frame of sample storage: beat-wide write in arrival order,
// combinational read of a whole natural-order beat.
module fft_reorder_bank
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int W     = FFT_W,
  parameter int LANES = FFT_LANES,
  parameter int BEATS = FFT_BEATS
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(BEATS)-1:0]   wbeat,
  input  logic signed [W-1:0]        wre [LANES],
  input  logic signed [W-1:0]        wim [LANES],
  input  logic [$clog2(BEATS)-1:0]   rbeat,
  output logic signed [W-1:0]        rre [LANES],
  output logic signed [W-1:0]        rim [LANES]
);

  localparam int LOGB = $clog2(BEATS);
  localparam int LOGL = $clog2(LANES);
  localparam int LOGN = LOGB + LOGL;

  logic signed [W-1:0] mem_re [BEATS][LANES];
  logic signed [W-1:0] mem_im [BEATS][LANES];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < LANES; l++) begin
        mem_re[wbeat][l] <= wre[l];
        mem_im[wbeat][l] <= wim[l];
      end
    end
  end

  // Output point m = rbeat*LANES + l lives at input point bitrev(m).
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      logic [LOGN-1:0] k;
      k = LOGN'(bitrev(32'({rbeat, LOGL'(l)}), LOGN));
      rre[l] = mem_re[k[LOGN-1:LOGL]][k[LOGL-1:0]];
      rim[l] = mem_im[k[LOGN-1:LOGL]][k[LOGL-1:0]];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong bit-reversed to natural-order reorder buffer with
// registered valid/ready output and frame-drop overflow detection.
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int W     = FFT_W,
  parameter int LANES = FFT_LANES,
  parameter int BEATS = FFT_BEATS
) (
  input  logic clk,
  input  logic rstn,
  fft_bitrev_reorder_if.slave bus
);

  localparam int              LOGB = $clog2(BEATS);
  localparam logic [LOGB-1:0] LAST = LOGB'(BEATS - 1);

  bank_state_e st [2];

  logic            wr_bank;
  logic            rd_bank;
  logic            drop;
  logic [LOGB-1:0] wr_beat;
  logic [LOGB-1:0] rd_beat;

  logic            first;
  logic            drop_now;
  logic            wr_acc;
  logic            nxt_bank;
  logic [LOGB-1:0] nxt_beat;
  logic            load;

  logic            out_valid;
  logic            out_last;
  logic            ovf_q;

  logic signed [W-1:0] out_re [LANES];
  logic signed [W-1:0] out_im [LANES];
  logic signed [W-1:0] in_re  [LANES];
  logic signed [W-1:0] in_im  [LANES];
  logic signed [W-1:0] b0_re  [LANES];
  logic signed [W-1:0] b0_im  [LANES];
  logic signed [W-1:0] b1_re  [LANES];
  logic signed [W-1:0] b1_im  [LANES];

  assign in_re = bus.din_re;
  assign in_im = bus.din_im;

  // A frame is kept or dropped as a whole, decided at its beat 0.
  assign first    = (wr_beat == '0);
  assign drop_now = first ? (st[wr_bank] != BANK_EMPTY) : drop;
  assign wr_acc   = bus.din_en && !drop_now;

  // Next beat for the output register; at a frame end it may
  // come straight from the other bank so there is no bubble.
  always_comb begin
    nxt_bank = rd_bank;
    nxt_beat = '0;
    load     = 1'b0;
    if (out_valid && rd_beat != LAST) begin
      nxt_beat = rd_beat + LOGB'(1);
      load     = bus.dout_ready;
    end else begin
      if (out_valid) nxt_bank = ~rd_bank;
      load = (!out_valid || bus.dout_ready)
          && (st[nxt_bank] == BANK_FULL);
    end
  end

  fft_reorder_bank #(
    .W     (W),
    .LANES (LANES),
    .BEATS (BEATS)
  ) u_bank0 (
    .clk   (clk),
    .we    (wr_acc && !wr_bank),
    .wbeat (wr_beat),
    .wre   (in_re),
    .wim   (in_im),
    .rbeat (nxt_beat),
    .rre   (b0_re),
    .rim   (b0_im)
  );

  fft_reorder_bank #(
    .W     (W),
    .LANES (LANES),
    .BEATS (BEATS)
  ) u_bank1 (
    .clk   (clk),
    .we    (wr_acc && wr_bank),
    .wbeat (wr_beat),
    .wre   (in_re),
    .wim   (in_im),
    .rbeat (nxt_beat),
    .rre   (b1_re),
    .rim   (b1_im)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st[0]     <= BANK_EMPTY;
      st[1]     <= BANK_EMPTY;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      drop      <= 1'b0;
      wr_beat   <= '0;
      rd_beat   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ovf_q     <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        out_re[l] <= '0;
        out_im[l] <= '0;
      end
    end else begin
      if (bus.din_en) begin
        wr_beat <= wr_beat + LOGB'(1);
        if (drop_now) begin
          ovf_q <= 1'b1;
          drop  <= (wr_beat != LAST);
        end else begin
          if (first) st[wr_bank] <= BANK_FILL;
          if (wr_beat == LAST) begin
            st[wr_bank] <= BANK_FULL;
            wr_bank     <= ~wr_bank;
          end
        end
      end
      if (!out_valid || bus.dout_ready) begin
        if (out_valid && rd_beat == LAST) st[rd_bank] <= BANK_EMPTY;
        rd_bank   <= nxt_bank;
        out_valid <= load;
        out_last  <= load && (nxt_beat == LAST);
        if (load) begin
          rd_beat <= nxt_beat;
          if (nxt_beat == '0) st[nxt_bank] <= BANK_DRAIN;
          for (int l = 0; l < LANES; l++) begin
            out_re[l] <= nxt_bank ? b1_re[l] : b0_re[l];
            out_im[l] <= nxt_bank ? b1_im[l] : b0_im[l];
          end
        end
      end
    end
  end

  assign bus.dout_valid = out_valid;
  assign bus.dout_last  = out_last;
  assign bus.ovf        = ovf_q;
  assign bus.dout_re    = out_re;
  assign bus.dout_im    = out_im;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: single, stalled,
// backpressured, back-to-back, overflow and reset scenarios.
module tb_fft_bitrev_reorder;

  localparam int W     = 24;
  localparam int LANES = 16;
  localparam int BEATS = 32;

  logic clk;
  logic rstn;

  fft_bitrev_reorder_if #(.W(W), .LANES(LANES)) bus ();

  fft_bitrev_reorder #(
    .W     (W),
    .LANES (LANES),
    .BEATS (BEATS)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;
  int exp_tags [64];
  int n_push = 0;
  int n_pop  = 0;
  int obeat  = 0;
  int run    = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rev9(input int m);
    int r;
    r = 0;
    for (int i = 0; i < 9; i++) r |= ((m >> i) & 1) << (8 - i);
    return r;
  endfunction

  // Scoreboard: every accepted beat is checked against the
  // expected frame tag and the beat/lane bit-reversal.
  task automatic collector();
    forever begin
      @(negedge clk);
      if (!rstn) begin
        n_pop = n_push;
        obeat = 0;
        run   = 0;
      end else begin
        run = bus.dout_valid ? run + 1 : 0;
        if (bus.dout_valid && bus.dout_ready) begin
          if (n_pop == n_push) begin
            check("extra_beat", 1, 0);
          end else begin
            for (int l = 0; l < LANES; l++) begin
              int v;
              v = exp_tags[n_pop] * 1024 + rev9(obeat * 16 + l);
              check("lane_re", int'(bus.dout_re[l]), v);
              check("lane_im", int'(bus.dout_im[l]), -v);
            end
            check("last", int'(bus.dout_last), (obeat == 31) ? 1 : 0);
            if (obeat == 31) begin
              obeat = 0;
              n_pop++;
            end else begin
              obeat++;
            end
          end
        end
      end
    end
  endtask

  task automatic drive_beat(input int tag, input int b);
    for (int l = 0; l < LANES; l++) begin
      int v;
      v = tag * 1024 + b * 16 + l;
      bus.din_re[l] = 24'(v);
      bus.din_im[l] = 24'(-v);
    end
  endtask

  task automatic send_frame(
    input int tag,
    input int gap,
    input int nb,
    input bit ovf_chk
  );
    for (int b = 0; b < nb; b++) begin
      drive_beat(tag, b);
      bus.din_en = 1'b1;
      @(posedge clk); #1;
      if (ovf_chk && b == 0) check("ovf_set", int'(bus.ovf), 1);
      bus.din_en = 1'b0;
      if (gap != 0) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && n_pop != n_push; i++) begin
      @(posedge clk); #1;
    end
    check("drain_done", n_pop, n_push);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_valid"}, int'(bus.dout_valid), 0);
    check({tag, "_last"}, int'(bus.dout_last), 0);
    check({tag, "_ovf"}, int'(bus.ovf), 0);
    check({tag, "_re0"}, int'(bus.dout_re[0]), 0);
    check({tag, "_im15"}, int'(bus.dout_im[15]), 0);
  endtask

  initial begin
    int mx;
    fork
      collector();
    join_none

    rstn           = 1'b0;
    bus.din_en     = 1'b0;
    bus.dout_ready = 1'b1;
    drive_beat(0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Single frame, din_re = k, with latency and hand values
    exp_tags[n_push] = 0;
    n_push++;
    send_frame(0, 0, BEATS, 1'b0);
    check("lat_t1_valid", int'(bus.dout_valid), 0);
    @(posedge clk); #1;
    check("lat_t2_valid", int'(bus.dout_valid), 1);
    check("b0_l0", int'(bus.dout_re[0]), 0);
    check("b0_l1", int'(bus.dout_re[1]), 256);
    check("b0_l2", int'(bus.dout_re[2]), 128);
    check("b0_im1", int'(bus.dout_im[1]), -256);
    wait_idle();

    // Input stalled every other cycle
    exp_tags[n_push] = 0;
    n_push++;
    send_frame(0, 1, BEATS, 1'b0);
    wait_idle();

    // Backpressure at output beat 5 for three cycles
    exp_tags[n_push] = 3;
    n_push++;
    send_frame(3, 0, BEATS, 1'b0);
    for (int i = 0; i < 200 && !(obeat == 5 && bus.dout_valid); i++) begin
      @(posedge clk); #1;
    end
    check("bp_reach", obeat, 5);
    bus.dout_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_valid", int'(bus.dout_valid), 1);
      check("bp_re3", int'(bus.dout_re[3]), 3476);
      check("bp_last", int'(bus.dout_last), 0);
    end
    bus.dout_ready = 1'b1;
    wait_idle();

    // Back-to-back frames A and B with no output gap
    exp_tags[n_push] = 10;
    n_push++;
    exp_tags[n_push] = 11;
    n_push++;
    send_frame(10, 0, BEATS, 1'b0);
    send_frame(11, 0, BEATS, 1'b0);
    mx = 0;
    for (int i = 0; i < 200; i++) begin
      if (run > mx) mx = run;
      if (n_pop == n_push) break;
      @(posedge clk); #1;
    end
    check("b2b_drain", n_pop, n_push);
    check("b2b_run", mx, 64);

    // Overflow: three frames while output is blocked
    bus.dout_ready = 1'b0;
    exp_tags[n_push] = 1;
    n_push++;
    exp_tags[n_push] = 2;
    n_push++;
    send_frame(1, 0, BEATS, 1'b0);
    send_frame(2, 0, BEATS, 1'b0);
    check("ovf_clear", int'(bus.ovf), 0);
    send_frame(3, 0, BEATS, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    bus.dout_ready = 1'b1;
    wait_idle();
    repeat (40) @(posedge clk);
    #1;
    check("ovf_no_f3", n_pop, n_push);
    check("ovf_sticky", int'(bus.ovf), 1);

    // Reset at input beat 17
    send_frame(5, 0, 17, 1'b0);
    rstn = 1'b0;
    #1;
    check_reset_outs("rst_in17");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    exp_tags[n_push] = 6;
    n_push++;
    send_frame(6, 0, BEATS, 1'b0);
    wait_idle();

    // Reset at output beat 10
    exp_tags[n_push] = 7;
    n_push++;
    send_frame(7, 0, BEATS, 1'b0);
    for (int i = 0; i < 200 && !(obeat == 10 && bus.dout_valid); i++) begin
      @(posedge clk); #1;
    end
    check("rst_out_reach", obeat, 10);
    rstn = 1'b0;
    #1;
    check_reset_outs("rst_out10");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    exp_tags[n_push] = 8;
    n_push++;
    send_frame(8, 0, BEATS, 1'b0);
    wait_idle();

    repeat (50) @(posedge clk);
    #1;
    check("no_extra", n_pop, n_push);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
